// File: rtl/sw_led_pkg.sv
// Shared display-mode encoding and table addressing for the switch-pattern LED block.
package sw_led_pkg;

   typedef enum logic [1:0] {
      MODE_STEADY = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_LATCH  = 2'd2,
      MODE_OFF    = 2'd3
   } mode_e;

   // Each channel owns a contiguous 2^sw_w slice of the minterm table.
   function automatic int unsigned table_index(input int unsigned ch,
                                               input int unsigned val,
                                               input int unsigned sw_w);
      return (ch << sw_w) + val;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a saturating equal-sample debouncer.
module sw_debounce
   import sw_led_pkg::*;
#(
   parameter int SW_W       = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] sw,
   output logic [SW_W-1:0] sw_stable
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [SW_W-1:0]  q1_r;
   logic [SW_W-1:0]  q2_r;
   logic [SW_W-1:0]  cand_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchronise, track the candidate value and accept it once it has held long enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_r      <= '0;
         q2_r      <= '0;
         cand_r    <= '0;
         cnt_r     <= '0;
         sw_stable <= '0;
      end else begin
         q1_r <= sw;
         q2_r <= q1_r;
         if (q2_r != cand_r) begin
            cand_r <= q2_r;
            cnt_r  <= '0;
         end else if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            sw_stable <= cand_r;
         end
      end
   end

endmodule

// File: rtl/sw_pattern_led.sv
// Debounced switch bank decoded through a per-channel minterm table onto LED channels.
module sw_pattern_led
   import sw_led_pkg::*;
#(
   parameter int SW_W       = 4,
   parameter int CH         = 2,
   parameter logic [CH*(2**SW_W)-1:0] TABLE = 32'h0306_3408,
   parameter int DEB_CYCLES = 4,
   parameter int BLINK_HALF = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] sw,
   input  logic [1:0]      mode,
   input  logic            clear,
   output logic [CH-1:0]   RGB_led_A,
   output logic [SW_W-1:0] sw_stable,
   output logic            hit
);

   localparam int BW = $clog2(BLINK_HALF);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

   logic [CH-1:0] match_s;
   logic [CH-1:0] match_q_r;
   logic [CH-1:0] match_prev_r;
   logic [CH-1:0] sticky_r;
   logic [BW-1:0] blink_cnt_r;
   logic          phase_r;

   sw_debounce #(
      .SW_W       (SW_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .sw_stable (sw_stable)
   );

   // Table lookup of the accepted switch value for every channel.
   always_comb begin
      match_s = '0;
      for (int c = 0; c < CH; c++) begin
         match_s[c] = TABLE[table_index(c, int'(sw_stable), SW_W)];
      end
   end

   // Match pipeline, rising-edge detect and sticky latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_q_r    <= '0;
         match_prev_r <= '0;
         sticky_r     <= '0;
         hit          <= 1'b0;
      end else begin
         match_q_r    <= match_s;
         match_prev_r <= match_q_r;
         hit          <= |(match_q_r & ~match_prev_r);
         if (clear) begin
            sticky_r <= '0;
         end else begin
            sticky_r <= sticky_r | match_q_r;
         end
      end
   end

   // Free-running blink timebase; phase starts high so blink opens with LEDs on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
      end else if (blink_cnt_r == BLINK_MAX) begin
         blink_cnt_r <= '0;
         phase_r     <= ~phase_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + BW'(1);
      end
   end

   // Mode-selected LED drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RGB_led_A <= '0;
      end else begin
         case (mode_e'(mode))
            MODE_STEADY: RGB_led_A <= match_q_r;
            MODE_BLINK:  RGB_led_A <= match_q_r & {CH{phase_r}};
            MODE_LATCH:  RGB_led_A <= sticky_r;
            MODE_OFF:    RGB_led_A <= '0;
            default:     RGB_led_A <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_pattern_led.sv
// Scoreboard bench: an edge-indexed behavioural model predicts outputs; a negedge monitor compares.
module tb_sw_pattern_led;

   localparam int SW_W = 4;
   localparam int CH   = 2;
   localparam int DEB  = 4;
   localparam int BH   = 8;
   localparam logic [31:0] TBL = 32'h0306_3408;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [SW_W-1:0] sw = '0;
   logic [1:0]      mode = 2'd0;
   logic            clear = 1'b0;
   logic [CH-1:0]   led;
   logic [SW_W-1:0] stable;
   logic            hit;

   always #5 clk = ~clk;

   sw_pattern_led dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .mode      (mode),
      .clear     (clear),
      .RGB_led_A (led),
      .sw_stable (stable),
      .hit       (hit)
   );

   typedef struct packed {
      logic [CH-1:0]   led;
      logic            hit;
      logic [SW_W-1:0] stable;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   // Model state: edges since reset release, raw sw at each edge, synchronised sample seen at each edge.
   int              e;
   logic [SW_W-1:0] sw_at[$];
   logic [SW_W-1:0] seen_hist[$];
   logic [SW_W-1:0] m_stable;
   logic [CH-1:0]   m_match, m_match2, m_sticky;

   function automatic logic [CH-1:0] lookup(input logic [SW_W-1:0] v);
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = TBL[c * 16 + int'(v)];
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      e = 0;
      sw_at.delete();
      seen_hist.delete();
      seen_hist.push_back('0);
      m_stable = '0;
      m_match  = '0;
      m_match2 = '0;
      m_sticky = '0;
   endtask

   // One clock edge of the specified behaviour, using inputs as they stand at the edge.
   task automatic model_step();
      exp_t x;
      logic [SW_W-1:0] seen, new_stable;
      logic all_eq, phase;
      e++;
      sw_at.push_back(sw);
      seen = (e >= 3) ? sw_at[e-3] : '0;
      seen_hist.push_back(seen);
      all_eq = (e >= DEB);
      if (all_eq) begin
         for (int j = e - DEB; j < e; j++) if (seen_hist[j] != seen) all_eq = 1'b0;
      end
      new_stable = all_eq ? seen : m_stable;
      phase = (((e - 1) / BH) % 2) == 0;
      x.hit = |(m_match & ~m_match2);
      case (mode)
         2'd0:    x.led = m_match;
         2'd1:    x.led = phase ? m_match : '0;
         2'd2:    x.led = m_sticky;
         default: x.led = '0;
      endcase
      x.stable = new_stable;
      m_sticky = clear ? '0 : (m_sticky | m_match);
      m_match2 = m_match;
      m_match  = lookup(m_stable);
      m_stable = new_stable;
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: every edge produces one output triple to compare.
   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("led", int'(led), int'(x.led));
         chk("hit", int'(hit), int'(x.hit));
         chk("sw_stable", int'(stable), int'(x.stable));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold;
      model_reset();
      rst_n = 1'b0; sw = 4'hF; mode = 2'd0; clear = 1'b0;
      #23;
      chk("reset_led", int'(led), 0);
      chk("reset_hit", int'(hit), 0);
      chk("reset_stable", int'(stable), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(12);

      // Steady: 0xF -> 0x8 then 0xC
      sw = 4'h8;
      run(6);
      chk("steady_stable_e6", int'(stable), 15);
      tick();
      chk("steady_stable_e7", int'(stable), 8);
      tick();
      chk("steady_led_e8", int'(led), 0);
      tick();
      chk("steady_led_e9", int'(led), 2);
      chk("steady_hit_e9", int'(hit), 1);
      run(6);
      sw = 4'hC;
      run(12);
      chk("steady_led_c", int'(led), 1);

      // Glitch: short pulse of 0x3 over settled 0
      sw = 4'h0;
      run(12);
      sw = 4'h3;
      run(3);
      sw = 4'h0;
      run(12);
      chk("glitch_stable", int'(stable), 0);
      chk("glitch_led", int'(led), 0);

      // Blink
      mode = 2'd1; sw = 4'hC;
      run(40);

      // Latch
      mode = 2'd2; sw = 4'h0;
      run(12);
      clear = 1'b1; tick(); clear = 1'b0;
      run(3);
      sw = 4'h1;
      run(12);
      sw = 4'h0;
      run(12);
      chk("latch_hold", int'(led), 2);
      clear = 1'b1; tick(); clear = 1'b0;
      tick();
      chk("latch_cleared", int'(led), 0);
      sw = 4'h1;
      run(12);
      clear = 1'b1; tick(); clear = 1'b0;
      tick();
      chk("latch_clear_match", int'(led), 0);
      tick();
      chk("latch_reset", int'(led), 2);

      // Reset mid-settle
      mode = 2'd0; sw = 4'h0;
      run(12);
      sw = 4'h2;
      run(5);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_led", int'(led), 0);
      chk("midrst_hit", int'(hit), 0);
      chk("midrst_stable", int'(stable), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      run(8);
      chk("midrst_led_e8", int'(led), 0);
      tick();
      chk("midrst_led_e9", int'(led), 2);

      // Randomised traffic
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            sw = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 10);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
         clear = ($urandom_range(0, 15) == 0);
         tick();
      end
      clear = 1'b0;
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
